// File: rtl/mic_level_meter.sv
// Microphone level meter: paces ADC conversions and turns each returned sample
// into a thermometer bar, with peak-hold/decay and sticky overrun detection.
`timescale 1ns/1ps
module mic_level_meter #(
  parameter int SAMPLE_DIV   = 2500,
  parameter int ADC_W        = 10,
  parameter int SEGMENTS     = 8,
  parameter int THRESH_BASE  = 'h1FF,
  parameter int THRESH_STEP  = 'h040,
  parameter int HOLD_SAMPLES = 4000,
  parameter int DECAY_STEP   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                mode,
  output logic                conv_start,
  input  logic                conv_done,
  input  logic [ADC_W-1:0]    conv_data,
  output logic [SEGMENTS-1:0] level,
  output logic                level_valid,
  output logic [ADC_W-1:0]    sample,
  output logic [ADC_W-1:0]    peak,
  output logic                overrun
);
  localparam int CNT_W  = $clog2(SAMPLE_DIV);
  localparam int HOLD_W = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
  localparam int CMP_W  = ADC_W + $clog2(SEGMENTS) + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state;
  logic [CNT_W-1:0]    tick_cnt;
  logic                tick;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [ADC_W-1:0]    peak_nxt, peak_dec, bar_val;
  logic [SEGMENTS-1:0] bar;

  assign tick = enable && (tick_cnt == CNT_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 tick_cnt <= '0;
    else if (!enable || tick) tick_cnt <= '0;
    else                     tick_cnt <= tick_cnt + 1'b1;
  end

  // Peak-hold next state, evaluated against the sample arriving this cycle.
  always_comb begin
    peak_dec = (int'(peak) >= DECAY_STEP) ? peak - ADC_W'(DECAY_STEP) : '0;
    peak_nxt = peak;
    hold_nxt = hold_cnt;
    if (conv_data >= peak) begin
      peak_nxt = conv_data;
      hold_nxt = HOLD_W'(HOLD_SAMPLES);
    end else if (hold_cnt != '0) begin
      hold_nxt = hold_cnt - 1'b1;
    end else begin
      peak_nxt = (conv_data > peak_dec) ? conv_data : peak_dec;
    end
    bar_val = mode ? peak_nxt : conv_data;
  end

  // Thresholds are widened so the top segments cannot wrap around and light early.
  for (genvar i = 0; i < SEGMENTS; i++) begin : g_seg
    localparam logic [CMP_W-1:0] THR = CMP_W'(THRESH_BASE + i * THRESH_STEP);
    assign bar[i] = (CMP_W'(bar_val) >= THR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      conv_start  <= 1'b0;
      level_valid <= 1'b0;
      level       <= '0;
      sample      <= '0;
      peak        <= '0;
      hold_cnt    <= '0;
      overrun     <= 1'b0;
    end else begin
      conv_start  <= 1'b0;
      level_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick) begin
            conv_start <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (conv_done) begin
            sample      <= conv_data;
            peak        <= peak_nxt;
            hold_cnt    <= hold_nxt;
            level       <= bar;
            level_valid <= 1'b1;
            state       <= S_IDLE;
          end else if (tick) begin
            overrun <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mic_level_meter.sv
// Scoreboard bench for mic_level_meter: an ADC responder pushes expected
// sample/peak/level results, a monitor pops them on every level_valid.
`timescale 1ns/1ps
module tb_mic_level_meter;
  localparam int DIV  = 20;
  localparam int HOLD = 3;
  localparam int DEC  = 16;

  logic       clk = 1'b0, rst = 1'b1, enable = 1'b0, mode = 1'b0, conv_done = 1'b0;
  logic [9:0] conv_data = '0;
  logic       conv_start, level_valid, overrun;
  logic [7:0] level;
  logic [9:0] sample, peak;

  mic_level_meter #(
    .SAMPLE_DIV(DIV), .ADC_W(10), .SEGMENTS(8), .THRESH_BASE('h1FF),
    .THRESH_STEP('h040), .HOLD_SAMPLES(HOLD), .DECAY_STEP(DEC)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .conv_start(conv_start), .conv_done(conv_done), .conv_data(conv_data),
    .level(level), .level_valid(level_valid), .sample(sample), .peak(peak),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { logic [9:0] s; logic [9:0] p; logic [7:0] l; } exp_t;
  exp_t       exp_q[$];
  exp_t       e;
  logic [9:0] adc_q[$];
  logic [7:0] lvl_log[$];
  logic [9:0] pk_log[$];
  int         start_q[$];
  int         n_chk = 0, n_fail = 0, cyc = 0, n_start = 0;
  bit         adc_en = 0, busy = 0;
  logic       done_q = 1'b0;
  logic [9:0] m_peak = '0, rsp_d;
  int         m_hold = 0;

  function automatic logic [7:0] exp_therm(input logic [9:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (int'(v) >= ('h1FF + i * 'h40));
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    done_q <= conv_done;
  end

  // Monitor: start log, latency check, scoreboard pop.
  always @(negedge clk) begin
    if (conv_start) begin
      n_start++;
      start_q.push_back(cyc);
    end
    if (level_valid || done_q) begin
      n_chk++;
      if (level_valid !== done_q) begin
        n_fail++;
        $display("FAIL valid_latency: level_valid=%0b, conv_done one cycle earlier=%0b", level_valid, done_q);
      end
    end
    if (level_valid) begin
      lvl_log.push_back(level);
      pk_log.push_back(peak);
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: level_valid with level=%h but nothing expected", level);
      end else begin
        e = exp_q.pop_front();
        if (sample !== e.s || peak !== e.p || level !== e.l) begin
          n_fail++;
          $display("FAIL scoreboard: got sample=%h peak=%h level=%h, want sample=%h peak=%h level=%h",
                   sample, peak, level, e.s, e.p, e.l);
        end
      end
    end
  end

  // ADC responder: answers 5 cycles after each start and predicts the result.
  always begin
    @(negedge clk);
    if (conv_start && adc_en) begin
      busy  = 1;
      rsp_d = (adc_q.size() > 0) ? adc_q.pop_front() : 10'h155;
      repeat (5) @(negedge clk);
      conv_data = rsp_d;
      conv_done = 1'b1;
      if (rsp_d >= m_peak) begin
        m_peak = rsp_d;
        m_hold = HOLD;
      end else if (m_hold > 0) begin
        m_hold--;
      end else begin
        m_peak = (int'(m_peak) >= DEC) ? m_peak - 10'(DEC) : 10'h000;
        if (rsp_d > m_peak) m_peak = rsp_d;
      end
      exp_q.push_back('{s: rsp_d, p: m_peak, l: exp_therm(mode ? m_peak : rsp_d)});
      @(negedge clk);
      conv_done = 1'b0;
      busy      = 0;
    end
  end

  task automatic do_reset();
    enable = 0;
    adc_en = 0;
    repeat (8) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    exp_q.delete(); adc_q.delete(); lvl_log.delete(); pk_log.delete(); start_q.delete();
    m_peak = '0; m_hold = 0; n_start = 0;
    rst = 0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k = 0;
    do begin
      @(negedge clk); #1; k++;
    end while ((busy || exp_q.size() != 0 || adc_q.size() != 0) && k < budget);
    n_chk++;
    if (busy || exp_q.size() != 0 || adc_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d results still pending after %0d cycles, want 0", name, exp_q.size() + adc_q.size(), budget);
    end
  endtask

  task automatic wait_start(input int budget, input string name, output int k);
    k = 0;
    do begin
      @(negedge clk); k++;
    end while (!conv_start && k < budget);
    n_chk++;
    if (!conv_start) begin
      n_fail++;
      $display("FAIL %s_no_start: no conv_start within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    enable = 1;
    repeat (4) begin
      @(negedge clk);
      n_chk++;
      if ({level, level_valid, conv_start, sample, peak, overrun} !== '0) begin
        n_fail++;
        $display("FAIL reset_state: level=%h valid=%b start=%b sample=%h peak=%h overrun=%b, want all 0",
                 level, level_valid, conv_start, sample, peak, overrun);
      end
    end
    do_reset();
  endtask

  task automatic test_pacing();
    do_reset();
    mode = 0;
    adc_en = 1;
    for (int i = 0; i < 6; i++) adc_q.push_back(10'($urandom_range(0, 1023)));
    enable = 1;
    wait_drain(250, "pacing");
    enable = 0;
    n_chk++;
    if (start_q.size() != 6) begin
      n_fail++;
      $display("FAIL pacing_count: %0d starts, want 6", start_q.size());
    end
    for (int i = 1; i < start_q.size(); i++) begin
      n_chk++;
      if (start_q[i] - start_q[i-1] != DIV) begin
        n_fail++;
        $display("FAIL pacing_period: start gap %0d, want %0d", start_q[i] - start_q[i-1], DIV);
      end
    end
    n_chk++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL pacing_overrun: overrun=%b, want 0", overrun);
    end
  endtask

  task automatic test_mode0_levels();
    logic [9:0] vals [4];
    logic [7:0] want [4];
    vals = '{10'h000, 10'h1FF, 10'h240, 10'h3FF};
    want = '{8'h00, 8'h01, 8'h03, 8'hFF};
    do_reset();
    mode = 0;
    adc_en = 1;
    for (int i = 0; i < 4; i++) adc_q.push_back(vals[i]);
    enable = 1;
    wait_drain(200, "mode0");
    enable = 0;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= lvl_log.size() || lvl_log[i] !== want[i]) begin
        n_fail++;
        $display("FAIL mode0_level[%0d]: level=%h, want %h", i, (i < lvl_log.size()) ? lvl_log[i] : 8'hxx, want[i]);
      end
    end
  endtask

  task automatic test_peak_hold();
    logic [9:0] wp;
    do_reset();
    mode = 1;
    adc_en = 1;
    adc_q.push_back(10'h3FF);
    repeat (14) adc_q.push_back(10'h200);
    enable = 1;
    wait_drain(400, "peak");
    enable = 0;
    for (int i = 0; i < 15; i++) begin
      wp = (i < 4) ? 10'h3FF : 10'(10'h3FF - 16 * (i - 3));
      n_chk++;
      if (i >= pk_log.size() || pk_log[i] !== wp) begin
        n_fail++;
        $display("FAIL peak_value[%0d]: peak=%h, want %h", i, (i < pk_log.size()) ? pk_log[i] : 10'hxxx, wp);
      end
      n_chk++;
      if (i >= lvl_log.size() || ((lvl_log[i] === 8'hFF) != (wp >= 10'h3BF))) begin
        n_fail++;
        $display("FAIL peak_level[%0d]: level=%h, want full bar only while peak >= 3BF (peak %h)",
                 i, (i < lvl_log.size()) ? lvl_log[i] : 8'hxx, wp);
      end
    end
  endtask

  task automatic test_no_done();
    int k;
    do_reset();
    enable = 1;
    wait_start(40, "nodone", k);
    repeat (10) @(negedge clk);
    n_chk++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL nodone_early_overrun: overrun=%b before second tick, want 0", overrun);
    end
    repeat (15) @(negedge clk);
    n_chk++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL nodone_overrun: overrun=%b after second tick, want 1", overrun);
    end
    repeat (60) @(negedge clk);
    n_chk++;
    if (n_start != 1 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL nodone_starts: %0d starts overrun=%b, want 1 start overrun=1", n_start, overrun);
    end
    enable = 0;
  endtask

  task automatic test_async_reset();
    int k;
    do_reset();
    adc_en = 1;
    adc_q.push_back(10'h3FF);
    enable = 1;
    wait_drain(60, "areset_fill");
    adc_en = 0;
    wait_start(40, "areset_wait", k);
    repeat (25) @(negedge clk);
    n_chk++;
    if (sample !== 10'h3FF || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: sample=%h overrun=%b, want 3ff and 1", sample, overrun);
    end
    #2 rst = 1;
    #0.5;
    n_chk++;
    if ({level, level_valid, conv_start, sample, peak, overrun} !== '0) begin
      n_fail++;
      $display("FAIL areset_immediate: level=%h valid=%b start=%b sample=%h peak=%h overrun=%b, want all 0",
               level, level_valid, conv_start, sample, peak, overrun);
    end
    #0.5 rst = 0;
    m_peak = '0; m_hold = 0;
    wait_start(60, "areset_restart", k);
    n_chk++;
    if (k != DIV) begin
      n_fail++;
      $display("FAIL areset_first_start: first start %0d cycles after release, want %0d", k, DIV);
    end
    enable = 0;
  endtask

  task automatic test_enable_drop();
    int k;
    do_reset();
    mode = 0;
    adc_en = 1;
    adc_q.push_back(10'h2C0);
    enable = 1;
    wait_start(40, "endrop", k);
    enable = 0;
    wait_drain(40, "endrop");
    n_chk++;
    if (sample !== 10'h2C0 || level !== 8'h0F || lvl_log.size() != 1) begin
      n_fail++;
      $display("FAIL endrop_update: sample=%h level=%h updates=%0d, want 2c0 0f 1", sample, level, lvl_log.size());
    end
    repeat (60) @(negedge clk);
    n_chk++;
    if (n_start != 1) begin
      n_fail++;
      $display("FAIL endrop_starts: %0d starts while disabled, want 1 total", n_start);
    end
  endtask

  initial begin
    test_reset();
    test_pacing();
    test_mode0_levels();
    test_peak_hold();
    test_no_done();
    test_async_reset();
    test_enable_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200 us");
    $fatal(1);
  end
endmodule

// File: doc/mic_level_meter.md
Name: mic_level_meter

Overview:
- Parametrised successor to the fixed 40 kHz microphone bar-graph stage.
- Paces ADC conversions at a programmable rate over a start/done handshake to the SPI ADC front end.
- Converts each returned sample into a SEGMENTS-wide thermometer bar with programmable thresholds.
- Adds peak-hold with decay, a sample-valid strobe, an enable, and overrun detection; drives the LED/visualiser logic.

Parameters:
- SAMPLE_DIV, 2500: clk cycles between conversion requests (2500 = 40 kHz at 100 MHz); must be ≥ 2.
- ADC_W, 10: ADC sample width.
- SEGMENTS, 8: number of bar segments.
- THRESH_BASE, 10'h1FF: threshold of segment 0.
- THRESH_STEP, 10'h040: threshold increment per segment.
- HOLD_SAMPLES, 4000: samples a new peak is held before decay starts.
- DECAY_STEP, 1: amount subtracted from peak per sample while decaying.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- enable  in  1  1 = generate conversions
- mode  in  1  0 = instantaneous bar, 1 = peak-hold bar
- conv_start  out  1  one-cycle request to ADC front end
- conv_done  in  1  one-cycle strobe, conv_data valid this cycle
- conv_data  in  ADC_W  converted sample
- level  out  SEGMENTS  thermometer bar, bit i = segment i lit
- level_valid  out  1  one-cycle strobe, level/sample/peak just updated
- sample  out  ADC_W  last captured sample
- peak  out  ADC_W  current peak-hold value
- overrun  out  1  sticky: rate tick occurred while a conversion was outstanding

Behaviour:
- Reset (async, rst=1) forces all of the following immediately: level=0, level_valid=0, conv_start=0, sample=0, peak=0, overrun=0, tick counter=0, hold counter=0, FSM=IDLE.
- Tick counter:
  - enable=1: counts 0..SAMPLE_DIV-1, then wraps to 0.
  - The tick is the cycle the counter equals SAMPLE_DIV-1.
  - enable=0: counter is held at 0; no ticks occur.
- FSM states IDLE and WAIT:
  - IDLE, tick: conv_start=1 for exactly that cycle; go to WAIT.
  - WAIT, conv_done=1: capture conv_data; go to IDLE.
  - WAIT, tick without conv_done: set overrun; no conv_start; stay in WAIT.
  - conv_done in IDLE is ignored.
  - Tick and conv_done in the same WAIT cycle: the sample is captured, no overrun is flagged, and no start is issued that cycle; the next start follows on the next tick.
- enable falling during WAIT does not abort; the in-flight conversion completes and updates outputs.
- On the capture edge (conv_done in WAIT), all of the following update together:
  - sample <= conv_data.
  - Peak update:
    - conv_data ≥ peak: peak <= conv_data and hold <= HOLD_SAMPLES.
    - Otherwise, if hold > 0: hold <= hold-1, peak unchanged.
    - Otherwise: peak <= max(conv_data, peak-DECAY_STEP), saturating at 0.
  - Peak tracking runs in both modes.
  - level <= therm(mode ? new peak : conv_data).
  - level_valid=1 during the following cycle only.
  - Latency: conv_done at cycle N → level/level_valid visible at cycle N+1.
- therm(v):
  - Bit i = (v ≥ THRESH_BASE + i*THRESH_STEP).
  - Compare in ADC_W+clog2(SEGMENTS)+1 bits so thresholds never wrap.
  - A threshold above 2^ADC_W-1 never lights.
  - Output is always a contiguous run of ones from bit 0.
- A mode change affects only the next level update; level is not recomputed between samples.
- overrun clears only on reset.

Test Plan:
- SAMPLE_DIV=20, enable=1, ADC model answers 5 cycles after start → conv_start pulses exactly every 20 cycles, overrun stays 0, level_valid one cycle after each conv_done.
- mode=0, samples 10'h000, 10'h1FF, 10'h240, 10'h3FF → level = 8'h00, 8'h01, 8'h03, 8'hFF respectively.
- mode=1, HOLD_SAMPLES=3, DECAY_STEP=16, sample 10'h3FF then repeated 10'h200:
  - peak is 3FF for 4 samples, then 3EF, 3DF, ...
  - peak never drops below 200.
  - level stays 8'hFF until peak drops below 10'h3BF.
- ADC model never returns conv_done → exactly one conv_start, overrun=1 from the second tick onward, no further conv_start.
- Assert rst for 1 ns mid-WAIT, asynchronous to clk → all outputs 0 immediately; after release, first conv_start occurs SAMPLE_DIV cycles later.
- enable dropped on the conv_start cycle, done returned 5 cycles later → sample/level update with level_valid; no further conv_start while enable=0.
